sort_stream_adapter: RTL



---
 rtl/sort_stream_adapter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sort_stream_adapter.sv
// Stream-side sequencer for the quicksort core: buffers N input words, feeds and runs the sorter,
// then drains the result and re-emits it as a valid/ready stream. Define SORT_ADAPT_CHECK_EN for order_err.
module sort_stream_adapter #(
  parameter int N       = 8,
  parameter int W       = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         timeout_err,
  output logic [W-1:0] s_xin,
  output logic         s_read,
  output logic         s_write,
  output logic         s_init,
  input  logic [W-1:0] s_xout,
  input  logic         s_qcomp
`ifdef SORT_ADAPT_CHECK_EN
  ,
  output logic         order_err
`endif
);

  // state | meaning
  // LOAD  | accept N input words into mem
  // FEED  | present mem[0..N-1] to the sorter with s_read
  // GAP1  | both strobes low so the sorter word counter clears
  // START | hold s_init until the sorter leaves idle (s_qcomp low)
  // WAIT  | wait for s_qcomp, abort to LOAD on timer terminal count
  // DRAIN | pulse s_write N times, capturing s_xout one cycle late
  // GAP2  | final capture of the last sorted word
  // EMIT  | stream mem[0..N-1] out with out_last on the final word
  typedef enum logic [2:0] {
    ST_LOAD, ST_FEED, ST_GAP1, ST_START, ST_WAIT, ST_DRAIN, ST_GAP2, ST_EMIT
  } state_t;

  localparam int AW = $clog2(N);
  localparam int IW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  state_t        state_q, state_nx;
  logic [IW-1:0] idx_q, idx_nx;
  logic [TW-1:0] tmr_q, tmr_nx;
  logic          tout_set;

  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  rd_word;
  logic [AW-1:0] cap_addr;
  logic          ld_we, cap_we, out_hs;

  assign out_hs   = out_valid && out_ready;
  assign ld_we    = in_ready && in_valid;
  assign cap_we   = (state_q == ST_DRAIN || state_q == ST_GAP2) && (idx_q != '0);
  assign cap_addr = AW'(idx_q - IW'(1));
  assign rd_word  = mem_q[idx_nx[AW-1:0]];

  always_comb begin
    state_nx = state_q;
    idx_nx   = idx_q;
    tmr_nx   = TMR_LOAD;
    tout_set = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (ld_we) begin
          if (idx_q == LAST_IDX) begin
            state_nx = ST_FEED;
            idx_nx   = '0;
          end else begin
            idx_nx = idx_q + IW'(1);
          end
        end
      end
      ST_FEED: begin
        if (idx_q == LAST_IDX) begin
          state_nx = ST_GAP1;
          idx_nx   = '0;
        end else begin
          idx_nx = idx_q + IW'(1);
        end
      end
      ST_GAP1: state_nx = ST_START;
      ST_START: begin
        if (!s_qcomp) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_nx = tmr_q - TW'(1);
        if (s_qcomp) begin
          state_nx = ST_DRAIN;
        end else if (tmr_q == '0) begin
          state_nx = ST_LOAD;
          idx_nx   = '0;
          tout_set = 1'b1;
        end
      end
      // idx runs to N here so GAP2 can capture mem[N-1] with the same lagged address
      ST_DRAIN: begin
        idx_nx = idx_q + IW'(1);
        if (idx_q == LAST_IDX) state_nx = ST_GAP2;
      end
      ST_GAP2: begin
        idx_nx   = '0;
        state_nx = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_hs) begin
          if (idx_q == LAST_IDX) begin
            state_nx = ST_LOAD;
            idx_nx   = '0;
          end else begin
            idx_nx = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_nx = ST_LOAD;
        idx_nx   = '0;
      end
    endcase
  end

  // Every output is a flop loaded from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      tmr_q       <= TMR_LOAD;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      s_read      <= 1'b0;
      s_write     <= 1'b0;
      s_init      <= 1'b0;
      s_xin       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_nx;
      idx_q       <= idx_nx;
      tmr_q       <= tmr_nx;
      in_ready    <= (state_nx == ST_LOAD);
      busy        <= (state_nx != ST_LOAD);
      out_valid   <= (state_nx == ST_EMIT);
      out_last    <= (state_nx == ST_EMIT) && (idx_nx == LAST_IDX);
      s_read      <= (state_nx == ST_FEED);
      s_write     <= (state_nx == ST_DRAIN);
      s_init      <= (state_nx == ST_START);
      s_xin       <= (state_nx == ST_FEED) ? rd_word : '0;
      if (state_nx == ST_EMIT) out_data <= rd_word;
      timeout_err <= timeout_err | tout_set;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_q[idx_q[AW-1:0]] <= in_data;
    end else if (cap_we) begin
      mem_q[cap_addr] <= s_xout;
    end
  end

`ifdef SORT_ADAPT_CHECK_EN
  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      order_err <= 1'b0;
    end else if (state_q == ST_EMIT && out_hs) begin
      prev_q <= out_data;
      if (idx_q != '0 && out_data < prev_q) order_err <= 1'b1;
    end
  end
`endif

endmodule
